// File: rtl/cpu_pkg.sv
// Types shared by the write-back path: register address, data word and
// the address/data pair that travels through the long-latency queue.
package cpu_pkg;

  typedef logic [3:0]  reg_addr_t;
  typedef logic [15:0] word_t;

  typedef struct packed {
    reg_addr_t addr;
    word_t     data;
  } wb_req_t;

  function automatic logic [15:0] addr_onehot(input reg_addr_t a);
    return 16'h0001 << a;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular queue of pending long-latency write-backs. A pushed entry
// becomes visible at the head only on the following cycle.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          push_i,
  input  wb_req_t       wdata_i,
  input  logic          pop_i,
  output wb_req_t       rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;
  wb_req_t       mem_q [FIFO_DEPTH];

  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  // Full blocks a push even when a pop frees a slot on the same edge.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    if (push_ok) wptr_d = wptr_q + PW'(1);
    if (pop_ok)  rptr_d = rptr_q + PW'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Merges single-cycle ALU results and queued long-latency results into one
// registered register-file write per cycle, with bounded queue starvation.
module reg_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          alu_v_i,
  input  logic [3:0]    alu_addr_i,
  input  logic [15:0]   alu_data_i,
  output logic          alu_ready_o,
  input  logic          ext_v_i,
  input  logic [3:0]    ext_addr_i,
  input  logic [15:0]   ext_data_i,
  output logic          ext_ready_o,
  input  logic          ext_issue_v_i,
  input  logic [3:0]    ext_issue_addr_i,
  output logic          wr_en_o,
  output logic [3:0]    wr_addr_o,
  output logic [15:0]   wr_data_o,
  output logic [15:0]   pending_o,
  output logic [CW-1:0] fifo_count_o
);

  logic          ready_q;
  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic [15:0]   pending_q, pending_d;
  logic          wr_en_q, wr_en_d;
  reg_addr_t     wr_addr_q, wr_addr_d;
  word_t         wr_data_q, wr_data_d;

  logic          fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic          alu_grant, starve_hit;
  wb_req_t       fifo_head;
  logic [CW-1:0] fifo_count;

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (fifo_push),
    .wdata_i ('{addr: ext_addr_i, data: ext_data_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Ready outputs come only from flops so upstream never sees a comb loop.
  assign starve_hit  = (starve_cnt_q == 4'(STARVE_LIMIT)) && !fifo_empty;
  assign alu_ready_o = ready_q && !starve_hit;
  assign ext_ready_o = ready_q && !fifo_full;
  assign fifo_push   = ext_v_i && ext_ready_o;

  always_comb begin
    alu_grant = 1'b0;
    fifo_pop  = 1'b0;
    if (starve_hit)                fifo_pop  = 1'b1;
    else if (alu_v_i && ready_q)   alu_grant = 1'b1;
    else if (!fifo_empty)          fifo_pop  = 1'b1;
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || fifo_pop)              starve_cnt_d = '0;
    else if (starve_cnt_q != 4'(STARVE_LIMIT)) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_comb begin
    wr_en_d   = alu_grant || fifo_pop;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (alu_grant) begin
      wr_addr_d = alu_addr_i;
      wr_data_d = alu_data_i;
    end else if (fifo_pop) begin
      wr_addr_d = fifo_head.addr;
      wr_data_d = fifo_head.data;
    end
  end

  // A new issue to the register being retired keeps it pending.
  always_comb begin
    pending_d = pending_q;
    if (fifo_pop)      pending_d = pending_d & ~addr_onehot(fifo_head.addr);
    if (ext_issue_v_i) pending_d = pending_d | addr_onehot(ext_issue_addr_i);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ready_q      <= 1'b0;
      starve_cnt_q <= '0;
      pending_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
    end else begin
      ready_q      <= 1'b1;
      starve_cnt_q <= starve_cnt_d;
      pending_q    <= pending_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_addr_o    = wr_addr_q;
  assign wr_data_o    = wr_data_q;
  assign pending_o    = pending_q;
  assign fifo_count_o = fifo_count;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter: expected writes are queued when the
// grant is known and compared as the register-file write appears.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        alu_v_i;
  logic [3:0]  alu_addr_i;
  logic [15:0] alu_data_i;
  logic        alu_ready_o;
  logic        ext_v_i;
  logic [3:0]  ext_addr_i;
  logic [15:0] ext_data_i;
  logic        ext_ready_o;
  logic        ext_issue_v_i;
  logic [3:0]  ext_issue_addr_i;
  logic        wr_en_o;
  logic [3:0]  wr_addr_o;
  logic [15:0] wr_data_o;
  logic [15:0] pending_o;
  logic [1:0]  fifo_count_o;

  logic [19:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  reg_wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .alu_v_i          (alu_v_i),
    .alu_addr_i       (alu_addr_i),
    .alu_data_i       (alu_data_i),
    .alu_ready_o      (alu_ready_o),
    .ext_v_i          (ext_v_i),
    .ext_addr_i       (ext_addr_i),
    .ext_data_i       (ext_data_i),
    .ext_ready_o      (ext_ready_o),
    .ext_issue_v_i    (ext_issue_v_i),
    .ext_issue_addr_i (ext_issue_addr_i),
    .wr_en_o          (wr_en_o),
    .wr_addr_o        (wr_addr_o),
    .wr_data_o        (wr_data_o),
    .pending_o        (pending_o),
    .fifo_count_o     (fifo_count_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic drive_alu(input logic v, input logic [3:0] a, input logic [15:0] d);
    alu_v_i = v; alu_addr_i = a; alu_data_i = d;
  endtask

  task automatic drive_ext(input logic v, input logic [3:0] a, input logic [15:0] d);
    ext_v_i = v; ext_addr_i = a; ext_data_i = d;
  endtask

  task automatic drive_issue(input logic v, input logic [3:0] a);
    ext_issue_v_i = v; ext_issue_addr_i = a;
  endtask

  task automatic drive_idle();
    drive_alu(1'b0, 4'h0, 16'h0);
    drive_ext(1'b0, 4'h0, 16'h0);
    drive_issue(1'b0, 4'h0);
  endtask

  // scoreboard monitor
  task automatic mon_wr();
    logic [19:0] e;
    if (wr_en_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("spurious_wr_en", 32'(wr_en_o), 32'h0);
      end else begin
        e = exp_q.pop_front();
        check_eq("wr_addr_data", {12'h0, wr_addr_o, wr_data_o}, {12'h0, e});
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    mon_wr();
  endtask

  initial begin
    int  j;
    logic c_done;
    logic acc;

    // reset state
    reset_i = 1'b1;
    drive_idle();
    step();
    step();
    check_eq("rst_wr_en", 32'(wr_en_o), 32'h0);
    check_eq("rst_pending", 32'(pending_o), 32'h0);
    check_eq("rst_count", 32'(fifo_count_o), 32'h0);
    check_eq("rst_alu_ready", 32'(alu_ready_o), 32'h0);
    check_eq("rst_ext_ready", 32'(ext_ready_o), 32'h0);
    reset_i = 1'b0;
    step();
    check_eq("post_rst_alu_ready", 32'(alu_ready_o), 32'h1);
    check_eq("post_rst_ext_ready", 32'(ext_ready_o), 32'h1);

    // single ALU write
    drive_alu(1'b1, 4'd3, 16'h00AB);
    exp_q.push_back({4'd3, 16'h00AB});
    step();
    check_eq("alu_wr_en", 32'(wr_en_o), 32'h1);
    drive_idle();
    step();
    check_eq("alu_wr_en_drop", 32'(wr_en_o), 32'h0);

    // ext issue, push, pop, scoreboard clear
    drive_issue(1'b1, 4'd5);
    step();
    check_eq("pend_set5", 32'(pending_o), 32'h0020);
    drive_issue(1'b0, 4'd0);
    drive_ext(1'b1, 4'd5, 16'hBEEF);
    step();
    check_eq("ext_count1", 32'(fifo_count_o), 32'h1);
    check_eq("ext_no_fallthru", 32'(wr_en_o), 32'h0);
    check_eq("pend_held5", 32'(pending_o), 32'h0020);
    drive_idle();
    exp_q.push_back({4'd5, 16'hBEEF});
    step();
    check_eq("ext_wr_en", 32'(wr_en_o), 32'h1);
    check_eq("pend_clr5", 32'(pending_o), 32'h0);
    check_eq("ext_count0", 32'(fifo_count_o), 32'h0);
    step();
    check_eq("ext_wr_en_drop", 32'(wr_en_o), 32'h0);
    check_eq("drain_t3", exp_q.size(), 0);

    // starvation preemption with ALU held valid
    j = 0;
    for (int i = 0; i < 8; i++) begin
      drive_alu(1'b1, 4'd1, 16'h2000 + 16'(j));
      if (i == 0) drive_ext(1'b1, 4'd7, 16'h1111);
      else        drive_ext(1'b0, 4'd0, 16'h0);
      check_eq($sformatf("starve_alu_ready_%0d", i), 32'(alu_ready_o), (i == 5) ? 32'h0 : 32'h1);
      if (i == 5) begin
        exp_q.push_back({4'd7, 16'h1111});
      end else begin
        exp_q.push_back({4'd1, 16'h2000 + 16'(j)});
        j++;
      end
      step();
    end
    drive_idle();
    step();
    check_eq("drain_t4", exp_q.size(), 0);

    // full FIFO, held third push, set-wins on pending
    j = 0;
    c_done = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive_alu(1'b1, 4'd1, 16'h4000 + 16'(j));
      if (i == 0)                drive_ext(1'b1, 4'd8, 16'hA001);
      else if (i == 1)           drive_ext(1'b1, 4'd9, 16'hA002);
      else if (!c_done)          drive_ext(1'b1, 4'd10, 16'hA003);
      else                       drive_ext(1'b0, 4'd0, 16'h0);
      if (i == 0 || i == 10) drive_issue(1'b1, 4'd9);
      else                   drive_issue(1'b0, 4'd0);
      if (i == 2) begin
        check_eq("full_count", 32'(fifo_count_o), 32'h2);
        check_eq("full_ext_ready", 32'(ext_ready_o), 32'h0);
      end
      if (i == 5)  check_eq("full_pop_ext_ready", 32'(ext_ready_o), 32'h0);
      if (i == 6)  check_eq("freed_ext_ready", 32'(ext_ready_o), 32'h1);
      if (i == 11) check_eq("pend_set_wins", 32'(pending_o), 32'h0200);
      check_eq($sformatf("full_alu_ready_%0d", i), 32'(alu_ready_o),
               (i == 5 || i == 10 || i == 15) ? 32'h0 : 32'h1);
      acc = ext_v_i && ext_ready_o;
      if (i >= 2 && acc) check_eq("third_push_cycle", i, 6);
      if (i == 5)       exp_q.push_back({4'd8, 16'hA001});
      else if (i == 10) exp_q.push_back({4'd9, 16'hA002});
      else if (i == 15) exp_q.push_back({4'd10, 16'hA003});
      else begin
        exp_q.push_back({4'd1, 16'h4000 + 16'(j)});
        j++;
      end
      step();
      if (i >= 2 && acc) c_done = 1'b1;
    end
    check_eq("third_push_taken", 32'(c_done), 32'h1);
    drive_idle();
    drive_ext(1'b1, 4'd9, 16'h0009);
    step();
    drive_idle();
    exp_q.push_back({4'd9, 16'h0009});
    step();
    check_eq("pend_clr9", 32'(pending_o), 32'h0);
    check_eq("drain_t5", exp_q.size(), 0);

    // asynchronous reset mid-operation
    drive_alu(1'b1, 4'd2, 16'h3000);
    drive_ext(1'b1, 4'd5, 16'h5555);
    drive_issue(1'b1, 4'd5);
    exp_q.push_back({4'd2, 16'h3000});
    step();
    drive_alu(1'b1, 4'd2, 16'h3001);
    drive_ext(1'b1, 4'd7, 16'h7777);
    drive_issue(1'b1, 4'd7);
    exp_q.push_back({4'd2, 16'h3001});
    step();
    check_eq("pre_rst_count", 32'(fifo_count_o), 32'h2);
    check_eq("pre_rst_pending", 32'(pending_o), 32'h00A0);
    check_eq("pre_rst_wr_en", 32'(wr_en_o), 32'h1);
    drive_alu(1'b1, 4'd2, 16'h3002);
    drive_ext(1'b0, 4'd0, 16'h0);
    drive_issue(1'b0, 4'd0);
    #2;
    reset_i = 1'b1;
    #1;
    check_eq("async_wr_en", 32'(wr_en_o), 32'h0);
    check_eq("async_count", 32'(fifo_count_o), 32'h0);
    check_eq("async_pending", 32'(pending_o), 32'h0);
    check_eq("async_wr_addr", 32'(wr_addr_o), 32'h0);
    drive_idle();
    step();
    step();
    reset_i = 1'b0;
    step();
    check_eq("rerst_alu_ready", 32'(alu_ready_o), 32'h1);
    check_eq("rerst_ext_ready", 32'(ext_ready_o), 32'h1);
    step();
    step();
    check_eq("rerst_count", 32'(fifo_count_o), 32'h0);
    check_eq("drain_final", exp_q.size(), 0);

    // report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
